cmd_response_tx: RTL and testbench



---
 rtl/cmd_types_pkg.sv | 42 ++++
 rtl/cmd_response_tx_p2s.sv | 53 +++++
 rtl/cmd_response_tx.sv | 200 ++++++++++++++++++++
 tb/tb_cmd_response_tx.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_types_pkg.sv
// Shared types and constants for the host command link.
// Response records, status codes and the transmit FSM encoding live here so
// the core and the link blocks agree on the field layout.
package cmd_types_pkg;

    typedef logic [7:0] byte_t;

    // Width of the payload field carried in every response record.
    localparam int CMD_MAX_PAYLOAD = 4;

    // Status codes echoed back to the host.
    localparam byte_t RESP_OK      = 8'h00;
    localparam byte_t RESP_BAD_CMD = 8'h01;
    localparam byte_t RESP_BUSY    = 8'h02;

    // Response record; code is the most significant field.
    typedef struct packed {
        byte_t                          code;
        byte_t                          status;
        byte_t                          payload_len;
        logic [CMD_MAX_PAYLOAD*8-1:0]   payload;
    } cmd_response_t;

    // Transmit framing states, one per frame field plus idle.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CODE,
        ST_STATUS,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK
    } tx_state_t;

    // Clamp a requested payload length to what a frame can carry.
    function automatic byte_t clamp_len(input byte_t len, input int max_len);
        if (int'(len) > max_len) begin
            return byte_t'(max_len);
        end
        return len;
    endfunction

endpackage

// File: rtl/cmd_response_tx_p2s.sv
// ParallelToSerialStream: loads a byte vector (most significant byte first)
// together with the number of bytes to send, then presents one byte at a
// time under a valid/ready handshake. Counterpart of the serial-to-parallel
// stream block on the receive side.
module ParallelToSerialStream #(
    parameter int NUM_BYTES = 7,
    parameter int CNT_W     = $clog2(NUM_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_load,
    input  logic [NUM_BYTES*8-1:0] i_load_vec,
    input  logic [CNT_W-1:0]       i_load_count,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [7:0]             o_data
);

    logic [NUM_BYTES*8-1:0] r_shift;
    logic [NUM_BYTES*8-1:0] w_shifted;
    logic [CNT_W-1:0]       r_count;

    // Each byte lane takes the lane below it; zeros enter at the bottom so
    // the register drains to all-zero once the vector has been sent.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
            if (gi == 0) begin : g_bottom
                assign w_shifted[7:0] = 8'h00;
            end else begin : g_upper
                assign w_shifted[gi*8 +: 8] = r_shift[(gi-1)*8 +: 8];
            end
        end
    endgenerate

    // Load a new vector, or advance one byte on every accepted handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_shift <= i_load_vec;
            r_count <= i_load_count;
        end else if (o_valid && i_ready) begin
            r_shift <= w_shifted;
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_shift[NUM_BYTES*8-1 -: 8];

endmodule

// File: rtl/cmd_response_tx.sv
// Transmit side of the host command link. Queues response records from the
// core and serializes each as code, status, N, N payload bytes, XOR checksum
// on a byte-wide valid/ready stream. Frames follow each other with no idle
// cycle when the queue already holds the next record.
module cmd_response_tx
    import cmd_types_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    // Must not exceed CMD_MAX_PAYLOAD, the width of the record payload field.
    parameter int MAX_PAYLOAD = CMD_MAX_PAYLOAD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          resp_in_valid,
    output logic          resp_in_ready,
    input  cmd_response_t resp_in_data,
    output logic          cmd_out_valid,
    input  logic          cmd_out_ready,
    output byte_t         cmd_out_data,
    output logic          busy
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int PAY_W     = CMD_MAX_PAYLOAD * 8;
    localparam int NUM_BYTES = 3 + CMD_MAX_PAYLOAD;
    localparam int P2S_CNT_W = $clog2(NUM_BYTES + 1);

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    cmd_response_t    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    cmd_response_t    w_head;

    assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty       = (r_count == '0);
    assign resp_in_ready = !w_full;
    assign w_push        = resp_in_valid && !w_full;
    // The head is read combinationally so a pop can latch it in the same
    // cycle, which is what keeps back-to-back frames gap-free.
    assign w_head        = r_mem[r_rd_ptr];

    // Queue storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= resp_in_data;
        end
    end

    // Pointers wrap naturally (depth is a power of two); push+pop holds count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly from the queue head
    // ------------------------------------------------------------------
    byte_t                  w_head_n;
    logic [PAY_W-1:0]       w_payload_aligned;
    logic [NUM_BYTES*8-1:0] w_load_vec;
    logic [P2S_CNT_W-1:0]   w_load_count;

    assign w_head_n = clamp_len(w_head.payload_len, MAX_PAYLOAD);
    // Move the low N payload bytes to the top of the field so they leave
    // most significant first, right after the length byte.
    assign w_payload_aligned = w_head.payload << (8 * (CMD_MAX_PAYLOAD - int'(w_head_n)));
    assign w_load_vec   = {w_head.code, w_head.status, w_head_n, w_payload_aligned};
    assign w_load_count = P2S_CNT_W'(3) + P2S_CNT_W'(w_head_n);

    logic  w_p2s_valid;
    byte_t w_p2s_data;

    ParallelToSerialStream #(
        .NUM_BYTES (NUM_BYTES),
        .CNT_W     (P2S_CNT_W)
    ) u_p2s (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_pop),
        .i_load_vec   (w_load_vec),
        .i_load_count (w_load_count),
        .i_ready      (cmd_out_ready),
        .o_valid      (w_p2s_valid),
        .o_data       (w_p2s_data)
    );

    // ------------------------------------------------------------------
    // Framing FSM and checksum
    // ------------------------------------------------------------------
    tx_state_t r_state;
    tx_state_t w_state_next;
    byte_t     r_pay_left;
    byte_t     r_chk;
    logic      w_hs;

    // Header and payload bytes come from the shifter; the checksum byte is
    // substituted in the CHK state. Both sources are registered, so the
    // presented byte holds for as long as the transport stalls.
    assign cmd_out_valid = (r_state == ST_CHK) || w_p2s_valid;
    assign cmd_out_data  = (r_state == ST_CHK) ? r_chk : w_p2s_data;
    assign w_hs          = cmd_out_valid && cmd_out_ready;
    assign busy          = (r_state != ST_IDLE) || !w_empty;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; also decides when the queue head is popped.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_CODE;
                end
            end
            ST_CODE: begin
                if (w_hs) begin
                    w_state_next = ST_STATUS;
                end
            end
            ST_STATUS: begin
                if (w_hs) begin
                    w_state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_hs) begin
                    w_state_next = (r_pay_left != 8'd0) ? ST_PAYLOAD : ST_CHK;
                end
            end
            ST_PAYLOAD: begin
                if (w_hs && (r_pay_left == 8'd1)) begin
                    w_state_next = ST_CHK;
                end
            end
            ST_CHK: begin
                if (w_hs) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_CODE;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Payload byte counter and running XOR; both restart when a record is
    // latched, which takes priority over the CHK handshake in that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pay_left <= 8'd0;
            r_chk      <= 8'd0;
        end else if (w_pop) begin
            r_pay_left <= w_head_n;
            r_chk      <= 8'd0;
        end else if (w_hs) begin
            r_chk <= r_chk ^ cmd_out_data;
            if (r_state == ST_PAYLOAD) begin
                r_pay_left <= r_pay_left - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_response_tx.sv
// Directed bench for cmd_response_tx: reset values, framing with and without
// payload, length clamping, queue-full backpressure with gap-free draining,
// output stability under stalls, and reset in the middle of a frame.
module tb_cmd_response_tx;
    import cmd_types_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          resp_in_valid = 1'b0;
    logic          resp_in_ready;
    cmd_response_t resp_in_data = '0;
    logic          cmd_out_valid;
    logic          cmd_out_ready = 1'b1;
    byte_t         cmd_out_data;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    byte_t rx_q[$];
    int    rx_cyc[$];

    cmd_response_tx dut (
        .clk           (clk),
        .rst           (rst),
        .resp_in_valid (resp_in_valid),
        .resp_in_ready (resp_in_ready),
        .resp_in_data  (resp_in_data),
        .cmd_out_valid (cmd_out_valid),
        .cmd_out_ready (cmd_out_ready),
        .cmd_out_data  (cmd_out_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every byte the transport accepts (reset cycles excluded).
    always @(negedge clk) begin
        if (!rst && cmd_out_valid && cmd_out_ready) begin
            rx_q.push_back(cmd_out_data);
            rx_cyc.push_back(cyc);
            $display("[%0d] byte %02h", cyc, cmd_out_data);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    function automatic byte_t rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    function automatic int rx_span(input int n);
        if (rx_cyc.size() >= n) return rx_cyc[n-1] - rx_cyc[0];
        return -1;
    endfunction

    function automatic cmd_response_t mk(input byte_t c, input byte_t s, input byte_t l,
                                         input logic [31:0] p);
        cmd_response_t r;
        r.code        = c;
        r.status      = s;
        r.payload_len = l;
        r.payload     = p;
        return r;
    endfunction

    task automatic clear_rx();
        rx_q.delete();
        rx_cyc.delete();
    endtask

    // Offer one record and return the cycle number in which it was accepted.
    task automatic push(input cmd_response_t rec, output int acc);
        acc = -1;
        resp_in_valid = 1'b1;
        resp_in_data  = rec;
        for (int k = 0; k < 100; k++) begin
            mid();
            if (resp_in_ready) begin
                acc = cyc;
                break;
            end
            tick();
        end
        tick();
        resp_in_valid = 1'b0;
        checks++;
        if (acc < 0) begin
            failures++;
            $display("FAIL push_accept got=never required=accepted code=%02h", rec.code);
        end else begin
            $display("[%0d] push code=%02h", acc, rec.code);
        end
    endtask

    task automatic wait_bytes(input int n, input int limit);
        for (int k = 0; k < limit && rx_q.size() < n; k++) mid();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        resp_in_valid = 1'b0;
        cmd_out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        mid();
        checks++;
        if (cmd_out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b required=0", cmd_out_valid);
        end
        checks++;
        if (cmd_out_data !== 8'h00) begin
            failures++; $display("FAIL reset_data got=%02h required=00", cmd_out_data);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b required=0", busy);
        end
        checks++;
        if (resp_in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready got=%b required=1", resp_in_ready);
        end
        tick();
    endtask

    task automatic test_len0();
        byte_t exp [4] = '{8'hA0, 8'h00, 8'h00, 8'hA0};
        int acc;
        clear_rx();
        cmd_out_ready = 1'b1;
        push(mk(8'hA0, RESP_OK, 8'd0, 32'h0), acc);
        wait_bytes(4, 40);
        checks++;
        if (rx_q.size() != 4) begin
            failures++; $display("FAIL len0_count got=%0d required=4", rx_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_at(i) !== exp[i]) begin
                failures++; $display("FAIL len0_byte%0d got=%02h required=%02h", i, rx_at(i), exp[i]);
            end
        end
        checks++;
        if (rx_cyc.size() < 1 || rx_cyc[0] != acc + 2) begin
            failures++;
            $display("FAIL len0_latency got=%0d required=%0d",
                     (rx_cyc.size() > 0) ? rx_cyc[0] : -1, acc + 2);
        end
        checks++;
        if (rx_span(4) != 3) begin
            failures++; $display("FAIL len0_gapfree got=%0d required=3", rx_span(4));
        end
        mid();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL len0_busy_after got=%b required=0", busy);
        end
        tick();
    endtask

    task automatic test_payload2();
        byte_t exp [6] = '{8'hA1, 8'h01, 8'h02, 8'hBE, 8'hEF, 8'hF3};
        int acc;
        clear_rx();
        cmd_out_ready = 1'b1;
        push(mk(8'hA1, RESP_BAD_CMD, 8'd2, 32'h0000BEEF), acc);
        wait_bytes(6, 40);
        checks++;
        if (rx_q.size() != 6) begin
            failures++; $display("FAIL pay2_count got=%0d required=6", rx_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx_at(i) !== exp[i]) begin
                failures++; $display("FAIL pay2_byte%0d got=%02h required=%02h", i, rx_at(i), exp[i]);
            end
        end
        checks++;
        if (rx_span(6) != 5) begin
            failures++; $display("FAIL pay2_gapfree got=%0d required=5", rx_span(6));
        end
        mid();
        tick();
    endtask

    task automatic test_clamp();
        byte_t exp [8] = '{8'hB0, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hF0};
        int acc;
        clear_rx();
        cmd_out_ready = 1'b1;
        push(mk(8'hB0, RESP_OK, 8'd7, 32'h11223344), acc);
        wait_bytes(8, 40);
        checks++;
        if (rx_q.size() != 8) begin
            failures++; $display("FAIL clamp_count got=%0d required=8", rx_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx_at(i) !== exp[i]) begin
                failures++; $display("FAIL clamp_byte%0d got=%02h required=%02h", i, rx_at(i), exp[i]);
            end
        end
        mid();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL clamp_busy_after got=%b required=0", busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        byte_t exp [23] = '{8'hC0, 8'h00, 8'h00, 8'hC0,
                            8'hC1, 8'h01, 8'h01, 8'hAA, 8'h6B,
                            8'hC2, 8'h02, 8'h00, 8'hC0,
                            8'hC3, 8'h00, 8'h02, 8'h12, 8'h34, 8'hE7,
                            8'hC4, 8'h01, 8'h00, 8'hC5};
        int acc;
        clear_rx();
        cmd_out_ready = 1'b0;
        push(mk(8'hC0, RESP_OK,      8'd0, 32'h0), acc);
        push(mk(8'hC1, RESP_BAD_CMD, 8'd1, 32'h000000AA), acc);
        push(mk(8'hC2, RESP_BUSY,    8'd0, 32'h0), acc);
        push(mk(8'hC3, RESP_OK,      8'd2, 32'h00001234), acc);
        push(mk(8'hC4, RESP_BAD_CMD, 8'd0, 32'h0), acc);
        mid();
        checks++;
        if (resp_in_ready !== 1'b0) begin
            failures++; $display("FAIL full_in_ready got=%b required=0", resp_in_ready);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL full_busy got=%b required=1", busy);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (cmd_out_valid !== 1'b1 || cmd_out_data !== 8'hC0) begin
                failures++;
                $display("FAIL full_hold%0d got=valid %b data %02h required=valid 1 data c0",
                         k, cmd_out_valid, cmd_out_data);
            end
            tick();
            mid();
        end
        checks++;
        if (rx_q.size() != 0) begin
            failures++; $display("FAIL full_no_output got=%0d required=0", rx_q.size());
        end
        tick();
        cmd_out_ready = 1'b1;
        wait_bytes(23, 80);
        checks++;
        if (rx_q.size() != 23) begin
            failures++; $display("FAIL b2b_count got=%0d required=23", rx_q.size());
        end
        for (int i = 0; i < 23; i++) begin
            checks++;
            if (rx_at(i) !== exp[i]) begin
                failures++; $display("FAIL b2b_byte%0d got=%02h required=%02h", i, rx_at(i), exp[i]);
            end
        end
        checks++;
        if (rx_span(23) != 22) begin
            failures++; $display("FAIL b2b_gapfree got=%0d required=22", rx_span(23));
        end
        mid();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL b2b_busy_after got=%b required=0", busy);
        end
        tick();
    endtask

    task automatic test_stall();
        byte_t exp [6] = '{8'hA1, 8'h01, 8'h02, 8'hBE, 8'hEF, 8'hF3};
        logic [31:0] pat = 32'b0110_1001_1100_0101_0011_1010_0110_0100;
        logic  prev_stall = 1'b0;
        byte_t prev_data  = 8'h00;
        int acc;
        clear_rx();
        cmd_out_ready = 1'b0;
        push(mk(8'hA1, RESP_BAD_CMD, 8'd2, 32'h0000BEEF), acc);
        for (int k = 0; k < 80 && rx_q.size() < 6; k++) begin
            cmd_out_ready = (k < 32) ? pat[k] : 1'b1;
            mid();
            if (prev_stall) begin
                checks++;
                if (cmd_out_valid !== 1'b1 || cmd_out_data !== prev_data) begin
                    failures++;
                    $display("FAIL stall_hold cyc%0d got=valid %b data %02h required=valid 1 data %02h",
                             cyc, cmd_out_valid, cmd_out_data, prev_data);
                end
            end
            prev_stall = cmd_out_valid && !cmd_out_ready;
            prev_data  = cmd_out_data;
            tick();
        end
        cmd_out_ready = 1'b1;
        checks++;
        if (rx_q.size() != 6) begin
            failures++; $display("FAIL stall_count got=%0d required=6", rx_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx_at(i) !== exp[i]) begin
                failures++; $display("FAIL stall_byte%0d got=%02h required=%02h", i, rx_at(i), exp[i]);
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_midframe();
        byte_t exp [3] = '{8'hD0, 8'h00, 8'h02};
        int acc;
        clear_rx();
        cmd_out_ready = 1'b0;
        push(mk(8'hD0, RESP_OK, 8'd2, 32'h00005566), acc);
        push(mk(8'hD1, RESP_OK, 8'd0, 32'h0), acc);
        push(mk(8'hD2, RESP_OK, 8'd0, 32'h0), acc);
        cmd_out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        mid();
        checks++;
        if (cmd_out_valid !== 1'b1 || cmd_out_data !== 8'h55) begin
            failures++;
            $display("FAIL rstmid_at_payload got=valid %b data %02h required=valid 1 data 55",
                     cmd_out_valid, cmd_out_data);
        end
        tick();
        rst = 1'b0;
        mid();
        checks++;
        if (cmd_out_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_valid got=%b required=0", cmd_out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_busy got=%b required=0", busy);
        end
        checks++;
        if (resp_in_ready !== 1'b1) begin
            failures++; $display("FAIL rstmid_in_ready got=%b required=1", resp_in_ready);
        end
        repeat (20) tick();
        checks++;
        if (rx_q.size() != 3) begin
            failures++; $display("FAIL rstmid_no_more got=%0d required=3", rx_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_at(i) !== exp[i]) begin
                failures++; $display("FAIL rstmid_byte%0d got=%02h required=%02h", i, rx_at(i), exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_len0();
        test_payload2();
        test_clamp();
        test_back_to_back();
        test_stall();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
